// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug command path:
// instruction codes, default geometry and the queued entry layout.
package nios_dbg_pkg;

  localparam logic [1:0] OCIMEM    = 2'd0;
  localparam logic [1:0] TRACEMEM  = 2'd1;
  localparam logic [1:0] BREAK     = 2'd2;
  localparam logic [1:0] TRACECTRL = 2'd3;

  localparam int IR_W_DEF    = 2;
  localparam int SR_W_DEF    = 38;
  localparam int ACT_BIT_DEF = 34;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] data;
  } dbg_entry_t;

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so the consumer
// always sees a stable head and the storage array needs only a registered read.
module nios_dbg_cmd_fifo
  import nios_dbg_pkg::*;
#(
  parameter int W     = IR_W_DEF + SR_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [W-1:0]  head_reg;

  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] rd_ptr_next;

  assign empty       = (level_reg == '0);
  assign full        = (level_reg == (AW+1)'(DEPTH));
  assign pop_ok      = pop & ~empty;
  assign push_ok     = push & (~full | pop_ok);
  assign rd_ptr_next = rd_ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Head refill: a push lands directly in the head register when the queue is
  // (or is about to become) empty; otherwise the next stored entry is read.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg <= '0;
    end else if (push_ok && (empty || (pop_ok && level_reg == (AW+1)'(1)))) begin
      head_reg <= push_data;
    end else if (pop_ok && level_reg > (AW+1)'(1)) begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_next;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head  = head_reg;
  assign level = level_reg;

endmodule

// File: rtl/nios_dbg_cmd_queue.sv
// System-clock-side debug command decoder: synchronises TCK-domain update
// pulses, queues completed scans and decodes them into per-channel strobes.
module nios_dbg_cmd_queue
  import nios_dbg_pkg::*;
#(
  parameter int IR_W    = IR_W_DEF,
  parameter int SR_W    = SR_W_DEF,
  parameter int N_CH    = 4,
  parameter int DEPTH   = 4,
  parameter int ACT_BIT = ACT_BIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [SR_W-1:0]          jdo,
  output logic [N_CH-1:0]          take_action,
  output logic [N_CH-1:0]          take_no_action,
  output logic                     unknown_cmd,
  output logic                     ir_update,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam logic [IR_W:0] CH_LIMIT = (IR_W+1)'(N_CH);

  logic [2:0]      udr_sync_reg;
  logic [2:0]      uir_sync_reg;
  logic            udr_edge;
  logic            uir_edge;
  logic            accept;
  logic            known;
  logic            full;
  logic [N_CH-1:0] act_next;
  logic [N_CH-1:0] nact_next;
  logic [N_CH-1:0] take_action_reg;
  logic [N_CH-1:0] take_no_action_reg;
  logic            unknown_reg;
  logic            ir_update_reg;
  logic            overflow_reg;
  logic            overflow_next;

  // Three-flop chains: s1/s2 resolve metastability, s2 & ~s3 marks one edge
  // per pulse regardless of its length.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_reg <= '0;
      uir_sync_reg <= '0;
    end else begin
      udr_sync_reg <= {udr_sync_reg[1:0], vs_udr};
      uir_sync_reg <= {uir_sync_reg[1:0], vs_uir};
    end
  end

  assign udr_edge = udr_sync_reg[1] & ~udr_sync_reg[2];
  assign uir_edge = uir_sync_reg[1] & ~uir_sync_reg[2];

  nios_dbg_cmd_fifo #(
    .W     (IR_W + SR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (udr_edge),
    .push_data ({ir_in, sr}),
    .pop       (accept),
    .head      ({cmd_ir, jdo}),
    .level     (level),
    .full      (full)
  );

  assign cmd_valid = (level != '0);
  assign accept    = cmd_valid & cmd_ready;
  assign known     = ({1'b0, cmd_ir} < CH_LIMIT);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_decode
      assign act_next[gi]  = accept & known & (cmd_ir == IR_W'(gi)) &  jdo[ACT_BIT];
      assign nact_next[gi] = accept & known & (cmd_ir == IR_W'(gi)) & ~jdo[ACT_BIT];
    end
  endgenerate

  // A dropped scan is one that arrives at full with no pop to make room;
  // a simultaneous set beats the clear.
  assign overflow_next = (udr_edge & full & ~accept) | (overflow_reg & ~ovf_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      take_action_reg    <= '0;
      take_no_action_reg <= '0;
      unknown_reg        <= 1'b0;
      ir_update_reg      <= 1'b0;
      overflow_reg       <= 1'b0;
    end else begin
      take_action_reg    <= act_next;
      take_no_action_reg <= nact_next;
      unknown_reg        <= accept & ~known;
      ir_update_reg      <= uir_edge;
      overflow_reg       <= overflow_next;
    end
  end

  assign take_action    = take_action_reg;
  assign take_no_action = take_no_action_reg;
  assign unknown_cmd    = unknown_reg;
  assign ir_update      = ir_update_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_nios_dbg_cmd_queue.sv
// Directed bench: two decoders (4 and 3 channels) share stimulus; expected
// strobes are queued at issue time and popped by an independent monitor.
module tb_nios_dbg_cmd_queue;
  import nios_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        cmd_ready = 1'b0;
  logic        ovf_clr = 1'b0;

  logic        cmd_valid, unknown_cmd, ir_update, overflow;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  level;

  logic        cmd_valid_3, unknown_cmd_3, ir_update_3, overflow_3;
  logic [1:0]  cmd_ir_3;
  logic [37:0] jdo_3;
  logic [2:0]  take_action_3, take_no_action_3;
  logic [2:0]  level_3;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  nios_dbg_cmd_queue #(.IR_W(2), .SR_W(38), .N_CH(4), .DEPTH(4), .ACT_BIT(34)) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action), .unknown_cmd(unknown_cmd),
    .ir_update(ir_update), .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  nios_dbg_cmd_queue #(.IR_W(2), .SR_W(38), .N_CH(3), .DEPTH(4), .ACT_BIT(34)) dut3 (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir_3), .jdo(jdo_3),
    .take_action(take_action_3), .take_no_action(take_no_action_3), .unknown_cmd(unknown_cmd_3),
    .ir_update(ir_update_3), .level(level_3), .overflow(overflow_3), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Packed expectation {act4, nact4, unk4, act3, nact3, unk3}.
  function automatic logic [15:0] exp_vec(input logic [1:0] ir, input logic act);
    logic [3:0] one;
    logic [3:0] a4, n4;
    logic [2:0] a3, n3;
    logic       u3;
    one = 4'b0001 << ir;
    a4  = act ? one : 4'b0000;
    n4  = act ? 4'b0000 : one;
    if (ir < 2'd3) begin
      a3 = a4[2:0]; n3 = n4[2:0]; u3 = 1'b0;
    end else begin
      a3 = 3'b000; n3 = 3'b000; u3 = 1'b1;
    end
    return {a4, n4, 1'b0, a3, n3, u3};
  endfunction

  task automatic scan(input logic [1:0] ir, input logic act, input int hi, input bit expect_out);
    if (expect_out) sb_q.push_back(exp_vec(ir, act));
    ir_in  = ir;
    sr     = {3'b101, act, 30'h0, 2'b00, ir};
    vs_udr = 1'b1;
    tick(hi);
    vs_udr = 1'b0;
    tick(3);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 50 && level != 3'd0; i++) tick();
    tick(2);
    cmd_ready = 1'b0;
    chk("drain_level", level, 3'd0);
  endtask

  // Monitor: every cycle with any strobe consumes exactly one expectation.
  initial begin
    logic [15:0] got, exp;
    forever begin
      @(negedge clk);
      got = {take_action, take_no_action, unknown_cmd, take_action_3, take_no_action_3, unknown_cmd_3};
      if (got != 16'h0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got %h expected none", got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL strobe: got %h expected %h", got, exp);
          end else begin
            $display("txn: act=%b nact=%b unk=%b | act3=%b nact3=%b unk3=%b",
                     got[15:12], got[11:8], got[7], got[6:4], got[3:1], got[0]);
          end
        end
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_level", level, 3'd0);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_cmd_ir", cmd_ir, 2'd0);
    chk("rst_jdo", jdo, 38'h0);
    chk("rst_strobes", {take_action, take_no_action, unknown_cmd}, 9'h0);
    chk("rst_ir_update", ir_update, 1'b0);
    reset = 1'b0;
    tick();

    // Single scan, consumer always ready: latency and one-cycle strobe.
    cmd_ready = 1'b1;
    ir_in = BREAK;
    sr = {3'b000, 1'b1, 34'h0_1234_5678};
    sb_q.push_back(exp_vec(2'd2, 1'b1));
    vs_udr = 1'b1;
    tick(2);
    chk("lat_valid_early", cmd_valid, 1'b0);
    tick();
    chk("lat_valid", cmd_valid, 1'b1);
    chk("lat_cmd_ir", cmd_ir, 2'd2);
    chk("lat_jdo", jdo, {3'b000, 1'b1, 34'h0_1234_5678});
    tick();
    chk("single_take", take_action, 4'b0100);
    chk("single_valid_after", cmd_valid, 1'b0);
    tick();
    chk("single_take_end", take_action, 4'b0000);
    vs_udr = 1'b0;
    tick(4);
    chk("single_level", level, 3'd0);
    cmd_ready = 1'b0;

    // Long and short pulses each push once.
    scan(2'd1, 1'b0, 20, 1'b1);
    chk("long_level", level, 3'd1);
    scan(2'd3, 1'b1, 1, 1'b1);
    chk("short_level", level, 3'd2);
    chk("short_head", cmd_ir, 2'd1);
    drain();

    // Fill, overflow on the fifth scan, in-order drain, clear.
    for (int i = 0; i < 4; i++) scan(2'(i), i[0], 2, 1'b1);
    scan(2'd1, 1'b1, 2, 1'b0);
    chk("fill_level", level, 3'd4);
    chk("fill_overflow", overflow, 1'b1);
    chk("fill_head", cmd_ir, 2'd0);
    drain();
    chk("ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Full queue with push and pop on the same edge.
    scan(2'd1, 1'b1, 1, 1'b1);
    scan(2'd2, 1'b1, 1, 1'b1);
    scan(2'd3, 1'b1, 1, 1'b1);
    scan(2'd0, 1'b1, 1, 1'b1);
    chk("full_level", level, 3'd4);
    ir_in = 2'd2;
    sr = {3'b101, 1'b0, 30'h0, 4'b0010};
    sb_q.push_back(exp_vec(2'd2, 1'b0));
    vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("pushpop_level", level, 3'd4);
    chk("pushpop_overflow", overflow, 1'b0);
    chk("pushpop_head", cmd_ir, 2'd2);
    vs_udr = 1'b0;
    tick(3);
    drain();

    // Code 3 is unknown to the 3-channel decoder only.
    cmd_ready = 1'b1;
    scan(2'd3, 1'b0, 1, 1'b1);
    tick(3);
    cmd_ready = 1'b0;

    // ir_update strobe timing; never queues.
    vs_uir = 1'b1;
    ir_in = TRACECTRL;
    tick(2);
    chk("uir_early", ir_update, 1'b0);
    tick();
    chk("uir_pulse", ir_update, 1'b1);
    tick();
    chk("uir_once", ir_update, 1'b0);
    vs_uir = 1'b0;
    tick(3);
    chk("uir_level", level, 3'd0);

    // Reset with entries queued discards them and any pending strobe.
    scan(2'd0, 1'b1, 1, 1'b0);
    scan(2'd1, 1'b1, 1, 1'b0);
    scan(2'd2, 1'b1, 1, 1'b0);
    chk("pre_reset_level", level, 3'd3);
    reset = 1'b1;
    cmd_ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_level", level, 3'd0);
    chk("mid_reset_valid", cmd_valid, 1'b0);
    tick();
    chk("mid_reset_strobes", {take_action, take_no_action, unknown_cmd}, 9'h0);
    tick(5);
    cmd_ready = 1'b0;

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios_dbg_cmd_queue.md
# nios_dbg_cmd_queue

Parametrised system-clock-side command decoder for the Nios II JTAG debug path. It synchronises update-DR and update-IR pulses arriving from the TCK domain and captures each completed scan (instruction plus shift register) into a DEPTH-entry queue. It releases commands to the CPU-side debug logic with a valid/ready handshake, emitting one-cycle per-channel take-action / take-no-action strobes. It supersedes the fixed 2-bit-IR, 38-bit, four-instruction, unbuffered decoder, which loses any scan that arrives while the previous one is still being acted on.

## Interface
Parameters:
- IR_W, 2, instruction register width.
- SR_W, 38, scan data width.
- N_CH, 4, number of decoded instruction channels; must satisfy N_CH ≤ 2^IR_W.
- DEPTH, 4, queue depth; power of two, ≥ 2.
- ACT_BIT, 34, index in the scan data that selects take_action (1) or take_no_action (0).

Ports:
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- vs_udr  in  1  update-DR pulse from the TCK domain, asynchronous to clk.
- vs_uir  in  1  update-IR pulse from the TCK domain, asynchronous to clk.
- ir_in  in  IR_W  current instruction; quasi-static around vs_uir/vs_udr.
- sr  in  SR_W  shift-register contents; quasi-static while vs_udr is high.
- cmd_valid  out  1  queue head is valid.
- cmd_ready  in  1  consumer accepts the head.
- cmd_ir  out  IR_W  instruction of the head entry.
- jdo  out  SR_W  data of the head entry.
- take_action  out  N_CH  one-hot, one-cycle strobe on accept when jdo[ACT_BIT]=1.
- take_no_action  out  N_CH  one-hot, one-cycle strobe on accept when jdo[ACT_BIT]=0.
- unknown_cmd  out  1  one-cycle strobe on accept when cmd_ir ≥ N_CH.
- ir_update  out  1  one-cycle strobe per synchronised vs_uir rising edge.
- level  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky; set when a scan is dropped.
- ovf_clr  in  1  clears overflow.

## Operation
- Synchronisation: vs_udr and vs_uir each pass through a three-flop chain (s1, s2, s3). A rising edge is detected as s2 & ~s3. Every synchronised edge yields exactly one event, however long the pulse.
- On a udr edge, push {ir_in, sr} sampled in that same cycle.
- On a uir edge, pulse ir_update. This event never writes the queue.
- Head presentation: cmd_valid = (level ≠ 0). cmd_ir and jdo always show the head entry and hold stable while cmd_valid & ~cmd_ready.
- Accept is cmd_valid & cmd_ready. On accept, pop the head and register the decode for the next cycle:
  - if cmd_ir < N_CH, pulse take_action[cmd_ir] or take_no_action[cmd_ir], selected by jdo[ACT_BIT];
  - otherwise pulse unknown_cmd.
- Full queue: a push without a simultaneous pop drops the scan and sets overflow. A push together with a pop at full is accepted, and level stays at DEPTH.
- Empty queue: a push is not bypassed to the head; cmd_valid rises in the following cycle.
- Pointers wrap modulo DEPTH. level carries the extra bit so full and empty are distinguishable.
- overflow: if a set and ovf_clr occur in the same cycle, set wins.
- Reset values: all synchroniser flops 0, level 0, cmd_valid 0, all strobes 0, overflow 0. cmd_ir and jdo read 0. Queue contents are don't-care.
- Reset mid-operation discards all queued entries and any in-flight strobe. A vs_udr pulse that is still high when reset deasserts is not counted: s3 resets to 0 and reset also zeroes s1/s2, so the edge is seen again only if the pulse is still high two cycles later.

## Timing
- vs_udr first sampled high at edge k: s1 at k, s2 at k+1, push at edge k+2, cmd_valid high after edge k+2. Latency is 3 clk edges.
- Accept at edge n produces its strobe during the cycle after edge n, exactly 1 cycle wide. The new head (or cmd_valid=0) is also visible after edge n.
- Back-to-back accepts give one strobe per cycle.
- ir_update is high during the cycle after edge k+2 for a vs_uir sampled high at edge k.
- Throughput is one push and one pop per cycle.

## Structure
- Shared package nios_dbg_pkg holds:
  - instruction code constants OCIMEM=0, TRACEMEM=1, BREAK=2, TRACECTRL=3;
  - default ACT_BIT=34;
  - the entry struct {ir, data}.
- Sub-module nios_dbg_cmd_fifo: synchronous FIFO of DEPTH entries with level output and push/pop. The top level holds the synchronisers, edge detection, decode and overflow logic.

## Test plan
- Single scan: ir_in=2, sr[34]=1, vs_udr high for 5 clk → cmd_valid 3 edges later; with cmd_ready=1, take_action=4'b0100 for exactly 1 cycle; no further strobes.
- Long and short pulses: a 20-cycle vs_udr high and a 1-cycle vs_udr high each → exactly one push; level=1.
- Fill and overflow: DEPTH=4, cmd_ready=0, 5 scans with ir=0..3 and 1 → level=4, overflow=1, head ir=0. Draining yields take strobes for ir 0,1,2,3 in order. ovf_clr → overflow=0.
- Full with simultaneous push and pop: level=4, accept coinciding with the push edge → level stays 4, no overflow, new entry is last out.
- Unknown code: N_CH=3, ir=3 scan accepted → unknown_cmd pulses, take_action and take_no_action stay 0.
- Reset mid-queue: level=3, assert reset for 1 cycle → level=0, cmd_valid=0, no strobe in the following cycle.
